// File: rtl/systolic_array_sequencer_if.sv
// ----------------------------------------------------------------------------
// systolic_array_sequencer_if
//   Bundles the host job interface and the array feed-control outputs of the
//   systolic array sequencer.
//
//   Host side : start, abort, depth_A, width_A, depth_B, width_B  (to sequencer)
//               busy, done, err, result_valid                     (from sequencer)
//   Array side: clear_acc, a_valid, a_kidx, b_valid, b_kidx       (from sequencer)
//
//   master : host / array view (drives job requests, observes controls)
//   slave  : sequencer view
// ----------------------------------------------------------------------------
interface systolic_array_sequencer_if #(
    parameter int SIZE  = 4,
    parameter int DIM_W = 3
);
    logic                    start;
    logic                    abort;
    logic [DIM_W-1:0]        depth_A;
    logic [DIM_W-1:0]        width_A;
    logic [DIM_W-1:0]        depth_B;
    logic [DIM_W-1:0]        width_B;
    logic                    busy;
    logic                    clear_acc;
    logic [SIZE-1:0]         a_valid;
    logic [SIZE*DIM_W-1:0]   a_kidx;
    logic [SIZE-1:0]         b_valid;
    logic [SIZE*DIM_W-1:0]   b_kidx;
    logic                    done;
    logic                    err;
    logic                    result_valid;

    modport master (
        output start, abort, depth_A, width_A, depth_B, width_B,
        input  busy, clear_acc, a_valid, a_kidx, b_valid, b_kidx,
               done, err, result_valid
    );

    modport slave (
        input  start, abort, depth_A, width_A, depth_B, width_B,
        output busy, clear_acc, a_valid, a_kidx, b_valid, b_kidx,
               done, err, result_valid
    );
endinterface

// File: rtl/systolic_array_sequencer.sv
// ----------------------------------------------------------------------------
// systolic_array_sequencer
//   Control FSM for a SIZE x SIZE systolic matrix-multiply array. Accepts a
//   job (M x K times K x N), clears the PE accumulators, feeds A rows and
//   B columns with a one-cycle-per-lane diagonal skew, waits for the array to
//   drain, then pulses done and raises result_valid.
//
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-low
//     bus    systolic_array_sequencer_if.slave
//              start/abort/dims in; busy, clear_acc, a/b feed valids and
//              packed K indices, done, err, result_valid out
// ----------------------------------------------------------------------------
module systolic_array_sequencer #(
    parameter int SIZE   = 4,
    parameter int DIM_W  = 3,
    parameter int PE_LAT = 1,
    parameter int CNT_W  = 5
) (
    input  logic                             clk,
    input  logic                             reset,
    systolic_array_sequencer_if.slave        bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    localparam logic [DIM_W-1:0] DIM_MAX  = DIM_W'(SIZE);
    // Last RUN count is K + 2*SIZE - 2 + PE_LAT - 1; only the K term varies.
    localparam logic [CNT_W-1:0] RUN_TAIL = CNT_W'(2 * SIZE - 2 + PE_LAT - 1);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       t_q, t_d;
    logic [DIM_W-1:0]       m_q, m_d;
    logic [DIM_W-1:0]       k_q, k_d;
    logic [DIM_W-1:0]       n_q, n_d;
    logic                   err_q, err_d;
    logic                   result_valid_q, result_valid_d;
    logic [SIZE-1:0]        a_valid_q, a_valid_d;
    logic [SIZE-1:0]        b_valid_q, b_valid_d;
    logic [SIZE*DIM_W-1:0]  a_kidx_q, a_kidx_d;
    logic [SIZE*DIM_W-1:0]  b_kidx_q, b_kidx_d;

    logic                   dims_legal;
    logic                   run_last;

    assign dims_legal = (bus.depth_A != '0) && (bus.depth_A <= DIM_MAX) &&
                        (bus.width_A != '0) && (bus.width_A <= DIM_MAX) &&
                        (bus.depth_B != '0) && (bus.depth_B <= DIM_MAX) &&
                        (bus.width_B != '0) && (bus.width_B <= DIM_MAX) &&
                        (bus.width_A == bus.depth_B);

    assign run_last = (t_q == (CNT_W'(k_q) + RUN_TAIL));

    // Next-state and job bookkeeping.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        state_d        = state_q;
        t_d            = t_q;
        m_d            = m_q;
        k_d            = k_q;
        n_d            = n_q;
        err_d          = err_q;
        result_valid_d = result_valid_q;

        case (state_q)
            S_IDLE: begin
                // start beats abort here; abort has no meaning while idle.
                if (bus.start) begin
                    t_d            = '0;
                    result_valid_d = 1'b0;
                    if (dims_legal) begin
                        m_d     = bus.depth_A;
                        k_d     = bus.width_A;
                        n_d     = bus.width_B;
                        err_d   = 1'b0;
                        state_d = S_CLEAR;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_CLEAR: begin
                t_d     = '0;
                state_d = bus.abort ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                if (bus.abort) begin
                    t_d     = '0;
                    state_d = S_IDLE;
                end else if (run_last) begin
                    t_d            = '0;
                    // Results are final in the DONE cycle itself.
                    result_valid_d = 1'b1;
                    state_d        = S_DONE;
                end else begin
                    t_d = t_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Feed valids/K indices are computed for the *next* cycle so the
    // registered outputs line up with the count the array sees this cycle.
    // Lane i is skewed by i cycles: it carries K index t - i while in range.
    always_comb begin
        a_valid_d = '0;
        a_kidx_d  = '0;
        b_valid_d = '0;
        b_kidx_d  = '0;
        if (state_d == S_RUN) begin
            for (int i = 0; i < SIZE; i++) begin
                if ((DIM_W'(i) < m_d) && (t_d >= CNT_W'(i)) &&
                    ((t_d - CNT_W'(i)) < CNT_W'(k_d))) begin
                    a_valid_d[i]                = 1'b1;
                    a_kidx_d[i*DIM_W +: DIM_W]  = DIM_W'(t_d - CNT_W'(i));
                end
                if ((DIM_W'(i) < n_d) && (t_d >= CNT_W'(i)) &&
                    ((t_d - CNT_W'(i)) < CNT_W'(k_d))) begin
                    b_valid_d[i]                = 1'b1;
                    b_kidx_d[i*DIM_W +: DIM_W]  = DIM_W'(t_d - CNT_W'(i));
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            t_q            <= '0;
            m_q            <= '0;
            k_q            <= '0;
            n_q            <= '0;
            err_q          <= 1'b0;
            result_valid_q <= 1'b0;
            a_valid_q      <= '0;
            b_valid_q      <= '0;
            a_kidx_q       <= '0;
            b_kidx_q       <= '0;
        end else begin
            state_q        <= state_d;
            t_q            <= t_d;
            m_q            <= m_d;
            k_q            <= k_d;
            n_q            <= n_d;
            err_q          <= err_d;
            result_valid_q <= result_valid_d;
            a_valid_q      <= a_valid_d;
            b_valid_q      <= b_valid_d;
            a_kidx_q       <= a_kidx_d;
            b_kidx_q       <= b_kidx_d;
        end
    end

    assign bus.busy         = (state_q == S_CLEAR) || (state_q == S_RUN);
    assign bus.clear_acc    = (state_q == S_CLEAR);
    assign bus.done         = (state_q == S_DONE);
    assign bus.err          = (state_q == S_DONE) && err_q;
    assign bus.result_valid = result_valid_q;
    assign bus.a_valid      = a_valid_q;
    assign bus.a_kidx       = a_kidx_q;
    assign bus.b_valid      = b_valid_q;
    assign bus.b_kidx       = b_kidx_q;

endmodule

// File: tb/tb_systolic_array_sequencer.sv
// ----------------------------------------------------------------------------
// tb_systolic_array_sequencer
//   Directed bench for systolic_array_sequencer. Each scenario task drives a
//   job and compares busy/clear_acc/done/err/result_valid and the feed lanes
//   cycle by cycle against values derived from the job dimensions. A small
//   behavioural systolic array, fed by the sequencer outputs, checks the
//   matrix product of a known 4x4 job.
// ----------------------------------------------------------------------------
module tb_systolic_array_sequencer;

    localparam int SIZE   = 4;
    localparam int DIM_W  = 3;
    localparam int PE_LAT = 1;
    localparam int CNT_W  = 5;

    logic clk = 1'b0;
    logic reset;

    int tests_run    = 0;
    int tests_failed = 0;

    systolic_array_sequencer_if #(.SIZE(SIZE), .DIM_W(DIM_W)) bus ();

    systolic_array_sequencer #(
        .SIZE   (SIZE),
        .DIM_W  (DIM_W),
        .PE_LAT (PE_LAT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural array model ----------------
    int mat_a [SIZE][SIZE];
    int mat_b [SIZE][SIZE];
    bit a_v_r [SIZE][SIZE];
    bit b_v_r [SIZE][SIZE];
    int a_d_r [SIZE][SIZE];
    int b_d_r [SIZE][SIZE];
    int acc   [SIZE][SIZE];

    always @(posedge clk) begin
        for (int i = 0; i < SIZE; i++) begin
            for (int j = 0; j < SIZE; j++) begin
                if (j == 0) begin
                    a_v_r[i][0] <= bus.a_valid[i];
                    a_d_r[i][0] <= mat_a[i][bus.a_kidx[i*DIM_W +: DIM_W]];
                end else begin
                    a_v_r[i][j] <= a_v_r[i][j-1];
                    a_d_r[i][j] <= a_d_r[i][j-1];
                end
                if (i == 0) begin
                    b_v_r[0][j] <= bus.b_valid[j];
                    b_d_r[0][j] <= mat_b[bus.b_kidx[j*DIM_W +: DIM_W]][j];
                end else begin
                    b_v_r[i][j] <= b_v_r[i-1][j];
                    b_d_r[i][j] <= b_d_r[i-1][j];
                end
                if (bus.clear_acc)
                    acc[i][j] <= 0;
                else if (a_v_r[i][j] && b_v_r[i][j])
                    acc[i][j] <= acc[i][j] + a_d_r[i][j] * b_d_r[i][j];
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one legal job and checks every cycle from accept to the IDLE cycle
    // after DONE. abort_t >= 0 raises abort during RUN count abort_t (or later
    // states, where it must be ignored). hold_start keeps start high.
    task automatic run_job(input string name, input int m, input int k, input int n,
                           input int abort_t, input bit abort_with_start,
                           input bit hold_start);
        int  done_c;
        int  t;
        bit  aborted;
        bit  in_run;
        bit  abort_effective;
        logic [4:0]            exp_st, got_st;
        logic [2*SIZE-1:0]     exp_v, got_v;
        logic [2*SIZE*DIM_W-1:0] exp_k, got_k;
        logic [SIZE*DIM_W-1:0] exp_ak, exp_bk;

        done_c = 2 + k + 2*SIZE - 2 + PE_LAT;
        abort_effective = (abort_t >= 0) && (abort_t + 2 <= done_c - 1);

        bus.depth_A = DIM_W'(m);
        bus.width_A = DIM_W'(k);
        bus.depth_B = DIM_W'(k);
        bus.width_B = DIM_W'(n);
        bus.start   = 1'b1;
        bus.abort   = abort_with_start;

        for (int c = 1; c <= done_c + 1; c++) begin
            step();
            bus.abort = 1'b0;
            if (c == 1) begin
                bus.start   = hold_start;
                bus.depth_A = 3'd7;
                bus.width_A = 3'd1;
                bus.depth_B = 3'd2;
                bus.width_B = 3'd0;
            end

            aborted = abort_effective && (c > abort_t + 2);
            in_run  = !aborted && (c >= 2) && (c <= done_c - 1);
            t       = c - 2;
            exp_st  = {!aborted && (c <= done_c - 1),   // busy
                       !aborted && (c == 1),            // clear_acc
                       !aborted && (c == done_c),       // done
                       1'b0,                            // err
                       !aborted && (c >= done_c)};      // result_valid
            exp_v  = '0;
            exp_ak = '0;
            exp_bk = '0;
            if (in_run) begin
                for (int i = 0; i < SIZE; i++) begin
                    if (i < m && t - i >= 0 && t - i < k) begin
                        exp_v[SIZE + i] = 1'b1;
                        exp_ak[i*DIM_W +: DIM_W] = DIM_W'(t - i);
                    end
                    if (i < n && t - i >= 0 && t - i < k) begin
                        exp_v[i] = 1'b1;
                        exp_bk[i*DIM_W +: DIM_W] = DIM_W'(t - i);
                    end
                end
            end
            exp_k = {exp_ak, exp_bk};

            got_st = {bus.busy, bus.clear_acc, bus.done, bus.err, bus.result_valid};
            got_v  = {bus.a_valid, bus.b_valid};
            got_k  = {bus.a_kidx, bus.b_kidx};

            tests_run++;
            if (got_st !== exp_st) begin
                tests_failed++;
                $display("FAIL %s c=%0d status{busy,clr,done,err,rv} got %b exp %b",
                         name, c, got_st, exp_st);
            end
            tests_run++;
            if (got_v !== exp_v) begin
                tests_failed++;
                $display("FAIL %s c=%0d valids{a,b} got %b exp %b", name, c, got_v, exp_v);
            end
            tests_run++;
            if (got_k !== exp_k) begin
                tests_failed++;
                $display("FAIL %s c=%0d kidx{a,b} got %h exp %h", name, c, got_k, exp_k);
            end

            if (abort_t >= 0 && c == abort_t + 2)
                bus.abort = 1'b1;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        bus.depth_A = '0;
        bus.width_A = '0;
        bus.depth_B = '0;
        bus.width_B = '0;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        #10;
        tests_run++;
        if ({bus.busy, bus.clear_acc, bus.done, bus.err, bus.result_valid} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_status got %b exp 00000",
                     {bus.busy, bus.clear_acc, bus.done, bus.err, bus.result_valid});
        end
        tests_run++;
        if ({bus.a_valid, bus.b_valid, bus.a_kidx, bus.b_kidx} !== '0) begin
            tests_failed++;
            $display("FAIL reset_feeds got %h exp 0",
                     {bus.a_valid, bus.b_valid, bus.a_kidx, bus.b_kidx});
        end
        @(posedge clk);
        #3;
        reset = 1'b1;
        step();
        tests_run++;
        if ({bus.busy, bus.done, bus.result_valid} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_release_idle got %b exp 000",
                     {bus.busy, bus.done, bus.result_valid});
        end
    endtask

    task automatic test_illegal_dims();
        logic [4*DIM_W-1:0] vec [4];
        vec[0] = {3'd4, 3'd4, 3'd3, 3'd4};  // width_A != depth_B
        vec[1] = {3'd4, 3'd4, 3'd4, 3'd0};  // width_B = 0
        vec[2] = {3'd4, 3'd4, 3'd4, 3'd5};  // width_B > SIZE
        vec[3] = {3'd0, 3'd2, 3'd2, 3'd2};  // depth_A = 0
        for (int v = 0; v < 4; v++) begin
            {bus.depth_A, bus.width_A, bus.depth_B, bus.width_B} = vec[v];
            bus.start = 1'b1;
            step();
            bus.start = 1'b0;
            tests_run++;
            if ({bus.busy, bus.clear_acc, bus.done, bus.err, bus.result_valid} !== 5'b00110) begin
                tests_failed++;
                $display("FAIL illegal_%0d_done status got %b exp 00110", v,
                         {bus.busy, bus.clear_acc, bus.done, bus.err, bus.result_valid});
            end
            tests_run++;
            if ({bus.a_valid, bus.b_valid} !== '0) begin
                tests_failed++;
                $display("FAIL illegal_%0d_valids got %b exp 0", v, {bus.a_valid, bus.b_valid});
            end
            step();
            tests_run++;
            if ({bus.busy, bus.clear_acc, bus.done, bus.err, bus.result_valid} !== 5'b00000) begin
                tests_failed++;
                $display("FAIL illegal_%0d_idle status got %b exp 00000", v,
                         {bus.busy, bus.clear_acc, bus.done, bus.err, bus.result_valid});
            end
        end
    endtask

    task automatic test_full_job();
        int ref_val;
        run_job("full_4x4x4", 4, 4, 4, -1, 1'b0, 1'b0);
        tests_run++;
        if (acc[0][0] !== 96) begin
            tests_failed++;
            $display("FAIL matmul_dout_0_0 got %0d exp 96", acc[0][0]);
        end
        for (int i = 0; i < SIZE; i++) begin
            for (int j = 0; j < SIZE; j++) begin
                ref_val = 0;
                for (int kk = 0; kk < SIZE; kk++)
                    ref_val += mat_a[i][kk] * mat_b[kk][j];
                tests_run++;
                if (acc[i][j] !== ref_val) begin
                    tests_failed++;
                    $display("FAIL matmul_dout_%0d_%0d got %0d exp %0d", i, j, acc[i][j], ref_val);
                end
            end
        end
    endtask

    task automatic test_partial_dims();
        run_job("partial_2x3x1", 2, 3, 1, -1, 1'b0, 1'b0);
        run_job("partial_3x1x4", 3, 1, 4, -1, 1'b0, 1'b0);
    endtask

    task automatic test_abort();
        run_job("abort_t5", 4, 4, 4, 5, 1'b0, 1'b0);
        run_job("after_abort", 4, 4, 4, -1, 1'b0, 1'b0);
        run_job("abort_with_start", 3, 2, 4, -1, 1'b1, 1'b0);
        // abort raised in the DONE cycle (count T+PE_LAT) must be ignored
        run_job("abort_in_done", 2, 2, 2, 2 + 2*SIZE - 2 + PE_LAT, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_job("b2b_first_held", 4, 4, 4, -1, 1'b0, 1'b1);
        run_job("b2b_second", 2, 3, 1, -1, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_run();
        bus.depth_A = 3'd4;
        bus.width_A = 3'd4;
        bus.depth_B = 3'd4;
        bus.width_B = 3'd4;
        bus.start   = 1'b1;
        step();
        bus.start = 1'b0;
        for (int c = 2; c <= 6; c++)
            step();
        tests_run++;
        if (bus.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrun_busy_before_reset got %b exp 1", bus.busy);
        end
        #2;
        reset = 1'b0;
        #1;
        tests_run++;
        if ({bus.busy, bus.clear_acc, bus.done, bus.err, bus.result_valid} !== 5'b0) begin
            tests_failed++;
            $display("FAIL midrun_reset_status got %b exp 00000",
                     {bus.busy, bus.clear_acc, bus.done, bus.err, bus.result_valid});
        end
        tests_run++;
        if ({bus.a_valid, bus.b_valid, bus.a_kidx, bus.b_kidx} !== '0) begin
            tests_failed++;
            $display("FAIL midrun_reset_feeds got %h exp 0",
                     {bus.a_valid, bus.b_valid, bus.a_kidx, bus.b_kidx});
        end
        #2;
        reset = 1'b1;
        for (int c = 0; c < 15; c++) begin
            step();
            tests_run++;
            if ({bus.busy, bus.done, bus.result_valid} !== 3'b000) begin
                tests_failed++;
                $display("FAIL midrun_after_reset c=%0d got %b exp 000", c,
                         {bus.busy, bus.done, bus.result_valid});
            end
        end
    endtask

    initial begin
        mat_a = '{'{5, 2, 6, 1}, '{0, 6, 2, 0}, '{3, 8, 1, 4}, '{1, 8, 5, 6}};
        mat_b = '{'{7, 5, 8, 0}, '{1, 8, 2, 6}, '{9, 4, 3, 8}, '{5, 3, 7, 9}};

        test_reset();
        test_illegal_dims();
        test_full_job();
        test_partial_dims();
        test_abort();
        test_back_to_back();
        test_reset_mid_run();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
